// File: rtl/ahb_slave_sram_pkg.sv
// Shared encodings, FSM state type and byte-lane helper for the AHB-Lite SRAM slave.
package ahb_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   // Byte lanes touched by a transfer of the given size at the given low address bits.
   function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
      case (size)
         HSIZE_BYTE: lane_mask = 4'b0001 << lo;
         HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: lane_mask = 4'b1111;
         default:    lane_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/ahb_slave_sram_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and the SRAM slave.
interface ahb_slave_sram_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic        HREADYIN;
   logic [31:0] HWDATA;
   logic [3:0]  WSTRB;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic [1:0]  HRESP;

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, WSTRB,
      output HRDATA, HREADYOUT, HRESP
   );

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADYIN, HWDATA, WSTRB,
      input  HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_byte_lane_decode.sv
// Address-phase byte-lane decode: lane mask plus misalignment flag.
module ahb_byte_lane_decode
   import ahb_slave_pkg::*;
(
   input  logic [2:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] lane,
   output logic       misalign
);

   assign lane     = lane_mask(size, addr_lo);
   assign misalign = ((size == HSIZE_HALF) && addr_lo[0]) ||
                     ((size == HSIZE_WORD) && (addr_lo != 2'b00));

endmodule

// File: rtl/ahb_slave_sram.sv
// AHB-Lite byte-addressed SRAM slave with wait states and two-cycle ERROR responses.
// Optional feature macro AHB_SLAVE_DMA_REQ_EN: control word at byte address MEM_DEPTH
// drives DmacReq (set by writing bit0=1, cleared by ReqAck).
module ahb_slave_sram
   import ahb_slave_pkg::*;
#(
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   ahb_slave_sram_if.slave  bus,
   output logic             DmacReq,
   input  logic             ReqAck
);

   localparam int AW = $clog2(MEM_DEPTH);
   localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [7:0]      mem [0:MEM_DEPTH-1];
   logic [AW-3:0]   word_q;
   logic            write_q;
   logic [3:0]      wmask_q;
   logic            ctrl_q;
   logic [3:0]      lane;
   logic            misalign;
   logic            accept, ctrl_hit, range_err, err, commit;
   logic [31:0]     mem_word;

   ahb_byte_lane_decode u_lane (
      .size    (bus.HSIZE),
      .addr_lo (bus.HADDR[1:0]),
      .lane    (lane),
      .misalign(misalign)
   );

   assign accept = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];

`ifdef AHB_SLAVE_DMA_REQ_EN
   assign ctrl_hit = (bus.HADDR == 32'(MEM_DEPTH)) && (bus.HSIZE == HSIZE_WORD);
`else
   logic unused_ack;
   assign ctrl_hit   = 1'b0;
   assign unused_ack = ReqAck;
`endif

   assign range_err = (bus.HADDR >= 32'(MEM_DEPTH)) && !ctrl_hit;
   assign err       = range_err || (bus.HSIZE > HSIZE_WORD) || misalign;
   assign commit    = (state == ST_DATA) && write_q;

   // State register; async reset abandons any in-flight data phase.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next state and bus response outputs.
   always_comb begin
      state_nxt     = state;
      bus.HREADYOUT = 1'b1;
      bus.HRESP     = HRESP_OKAY;
      bus.HRDATA    = '0;
      unique case (state)
         ST_WAIT: begin
            bus.HREADYOUT = 1'b0;
            if (cnt == CW'(1)) state_nxt = ST_DATA;
         end
         ST_ERR1: begin
            bus.HREADYOUT = 1'b0;
            bus.HRESP     = HRESP_ERROR;
            state_nxt     = ST_ERR2;
         end
         default: begin
            if (state == ST_ERR2) bus.HRESP = HRESP_ERROR;
            if (state == ST_DATA) bus.HRDATA = ctrl_q ? {31'b0, DmacReq} : mem_word;
            if (!accept)            state_nxt = ST_IDLE;
            else if (err)           state_nxt = ST_ERR1;
            else if (WAIT_STATES == 0) state_nxt = ST_DATA;
            else                    state_nxt = ST_WAIT;
         end
      endcase
   end

   // Address-phase capture and wait-state countdown.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         word_q  <= '0;
         write_q <= 1'b0;
         wmask_q <= '0;
         ctrl_q  <= 1'b0;
         cnt     <= '0;
      end else if (accept && (state_nxt != ST_WAIT || state != ST_WAIT)
                   && state != ST_ERR1) begin
         word_q  <= bus.HADDR[AW-1:2];
         write_q <= bus.HWRITE & ~err;
         wmask_q <= lane & bus.WSTRB;
         ctrl_q  <= ctrl_hit;
         cnt     <= CW'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Little-endian word view of the addressed memory row.
   always_comb begin
      mem_word = '0;
      for (int c = 0; c < 4; c++) mem_word[8*c +: 8] = mem[{word_q, 2'(c)}];
   end

   // Byte-masked write on the edge that completes the data phase; memory has no reset.
   always_ff @(posedge HCLK) begin
      if (commit && !ctrl_q) begin
         for (int c = 0; c < 4; c++)
            if (wmask_q[c]) mem[{word_q, 2'(c)}] <= bus.HWDATA[8*c +: 8];
      end
   end

`ifdef AHB_SLAVE_DMA_REQ_EN
   // DMA request flop: acknowledge has priority over a same-cycle set.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)                             DmacReq <= 1'b0;
      else if (ReqAck)                          DmacReq <= 1'b0;
      else if (commit && ctrl_q && bus.HWDATA[0]) DmacReq <= 1'b1;
   end
`else
   assign DmacReq = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Directed, table-driven bench for ahb_slave_sram (zero-wait and two-wait instances).
module tb_ahb_slave_sram;
   import ahb_slave_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        tgt;
   logic        hsel, hwrite, req_ack;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] haddr, hwdata;
   logic [3:0]  wstrb;
   logic        dreq0, dreq2;

   ahb_slave_sram_if b0();
   ahb_slave_sram_if b2();

   assign b0.HSEL = hsel & ~tgt;
   assign b2.HSEL = hsel & tgt;
   assign b0.HADDR = haddr;   assign b2.HADDR = haddr;
   assign b0.HTRANS = htrans; assign b2.HTRANS = htrans;
   assign b0.HWRITE = hwrite; assign b2.HWRITE = hwrite;
   assign b0.HSIZE = hsize;   assign b2.HSIZE = hsize;
   assign b0.HWDATA = hwdata; assign b2.HWDATA = hwdata;
   assign b0.WSTRB = wstrb;   assign b2.WSTRB = wstrb;
   assign b0.HREADYIN = b0.HREADYOUT;
   assign b2.HREADYIN = b2.HREADYOUT;

   logic        ready, dreq;
   logic [1:0]  resp;
   logic [31:0] rdata;
   assign ready = tgt ? b2.HREADYOUT : b0.HREADYOUT;
   assign resp  = tgt ? b2.HRESP     : b0.HRESP;
   assign rdata = tgt ? b2.HRDATA    : b0.HRDATA;
   assign dreq  = tgt ? dreq2        : dreq0;

   ahb_slave_sram #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESETn(rst_n), .bus(b0), .DmacReq(dreq0), .ReqAck(req_ack));
   ahb_slave_sram #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
      .HCLK(clk), .HRESETn(rst_n), .bus(b2), .DmacReq(dreq2), .ReqAck(req_ack));

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_bus();
      hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      hsize = HSIZE_BYTE; haddr = '0; wstrb = '0;
   endtask

   // One isolated transfer; returns data/response seen on the completing cycle.
   task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [3:0] st, input logic [31:0] wd,
                       output logic [31:0] rd, output logic [1:0] r_first,
                       output logic [1:0] r_last, output int waits);
      @(negedge clk);
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = w; haddr = a; hsize = sz; wstrb = st;
      @(negedge clk);
      idle_bus();
      hwdata  = wd;
      waits   = 0;
      r_first = resp;
      while (!ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      rd     = rdata;
      r_last = resp;
   endtask

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [3:0]  st;
      logic [31:0] wd;
      bit          err;
      bit          chk_rd;
      logic [31:0] rd;
   } vec_t;

   function automatic vec_t mk(bit w, logic [31:0] a, logic [2:0] sz, logic [3:0] st,
                               logic [31:0] wd, bit err, bit chk_rd, logic [31:0] rd);
      vec_t v;
      v.w = w; v.a = a; v.sz = sz; v.st = st; v.wd = wd;
      v.err = err; v.chk_rd = chk_rd; v.rd = rd;
      return v;
   endfunction

   vec_t vt[$];

   initial begin
      logic [31:0] rd;
      logic [1:0]  rf, rl;
      int          waits, low;

      tgt = 1'b0; req_ack = 1'b0; hwdata = '0;
      idle_bus();
      for (int i = 0; i < 256; i++) begin
         dut0.mem[i] = 8'(i);
         dut2.mem[i] = 8'(i);
      end

      //           w  addr    size        strb     wdata         err chk expected
      vt.push_back(mk(1, 32'h10,  HSIZE_WORD, 4'hF, 32'hDEADBEEF, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'h10,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF));
      vt.push_back(mk(1, 32'h21,  HSIZE_BYTE, 4'hF, 32'h0000AB00, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'h20,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'h2322AB20));
      vt.push_back(mk(1, 32'h32,  HSIZE_HALF, 4'hF, 32'hCAFE1234, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'h30,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'hCAFE3130));
      vt.push_back(mk(1, 32'h40,  HSIZE_WORD, 4'h5, 32'hAABBCCDD, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'h40,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'h43BB41DD));
      vt.push_back(mk(1, 32'h03,  HSIZE_HALF, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0));
      vt.push_back(mk(0, 32'h02,  HSIZE_HALF, 4'hF, 32'h0,        0, 1, 32'h03020100));
      vt.push_back(mk(1, 32'h50,  3'b011,     4'hF, 32'hFFFFFFFF, 1, 1, 32'h0));
      vt.push_back(mk(0, 32'h50,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'h53525150));
      vt.push_back(mk(0, 32'h42,  HSIZE_WORD, 4'hF, 32'h0,        1, 1, 32'h0));
      vt.push_back(mk(0, 32'h104, HSIZE_WORD, 4'hF, 32'h0,        1, 1, 32'h0));
      vt.push_back(mk(0, 32'hFC,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'hFFFEFDFC));
      vt.push_back(mk(1, 32'hFF,  HSIZE_BYTE, 4'h7, 32'h11000000, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'hFC,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'hFFFEFDFC));
      vt.push_back(mk(1, 32'hFF,  HSIZE_BYTE, 4'h8, 32'h11223344, 0, 0, 32'h0));
      vt.push_back(mk(0, 32'hFC,  HSIZE_WORD, 4'hF, 32'h0,        0, 1, 32'h11FEFDFC));

      // Reset values
      #1;
      chk("rst_ready", ready, 1);
      chk("rst_resp", resp, HRESP_OKAY);
      chk("rst_rdata", rdata, 0);
      chk("rst_dreq", dreq, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table vectors on the zero-wait instance
      foreach (vt[i]) begin
         xfer(vt[i].w, vt[i].a, vt[i].sz, vt[i].st, vt[i].wd, rd, rf, rl, waits);
         if (vt[i].err) begin
            chk($sformatf("v%0d_err_waits", i), 32'(waits), 1);
            chk($sformatf("v%0d_err_resp1", i), rf, HRESP_ERROR);
            chk($sformatf("v%0d_err_resp2", i), rl, HRESP_ERROR);
         end else begin
            chk($sformatf("v%0d_waits", i), 32'(waits), 0);
            chk($sformatf("v%0d_resp", i), rl, HRESP_OKAY);
         end
         if (vt[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      end

      // Back-to-back write then read of the same word
      @(negedge clk);
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h08;
      hsize = HSIZE_WORD; wstrb = 4'hF;
      @(negedge clk);
      chk("pipe_wr_ready", ready, 1);
      hwdata = 32'h12345678; hwrite = 1'b0;
      @(negedge clk);
      idle_bus();
      chk("pipe_rd_ready", ready, 1);
      chk("pipe_rd_resp", resp, HRESP_OKAY);
      chk("pipe_rd_data", rdata, 32'h12345678);

      // Control address at MEM_DEPTH
`ifdef AHB_SLAVE_DMA_REQ_EN
      xfer(1, 32'h100, HSIZE_WORD, 4'hF, 32'h1, rd, rf, rl, waits);
      chk("ctrl_wr_resp", rl, HRESP_OKAY);
      @(negedge clk);
      chk("dreq_set", dreq, 1);
      xfer(0, 32'h100, HSIZE_WORD, 4'hF, 32'h0, rd, rf, rl, waits);
      chk("ctrl_rd_data", rd, 32'h1);
      xfer(0, 32'h100, HSIZE_BYTE, 4'hF, 32'h0, rd, rf, rl, waits);
      chk("ctrl_byte_err", rl, HRESP_ERROR);
      @(negedge clk); req_ack = 1'b1;
      @(negedge clk); req_ack = 1'b0;
      chk("dreq_ack_clear", dreq, 0);
`else
      xfer(0, 32'h100, HSIZE_WORD, 4'hF, 32'h0, rd, rf, rl, waits);
      chk("oob_rd_waits", 32'(waits), 1);
      chk("oob_rd_resp1", rf, HRESP_ERROR);
      chk("oob_rd_resp2", rl, HRESP_ERROR);
      chk("oob_rd_data", rd, 0);
      xfer(1, 32'h100, HSIZE_WORD, 4'hF, 32'h1, rd, rf, rl, waits);
      chk("oob_wr_resp", rl, HRESP_ERROR);
      @(negedge clk); req_ack = 1'b1;
      @(negedge clk); req_ack = 1'b0;
      chk("dreq_tied", dreq, 0);
`endif

      // Two-wait-state instance: read latency
      @(negedge clk);
      tgt = 1'b1;
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h04;
      hsize = HSIZE_WORD; wstrb = 4'hF;
      @(negedge clk);
      idle_bus();
      chk("ws_rdata_wait", rdata, 0);
      low = 0;
      while (!ready && low < 10) begin
         @(negedge clk);
         low++;
      end
      chk("ws_low_cycles", 32'(low), 2);
      chk("ws_rdata", rdata, 32'h07060504);
      chk("ws_resp", resp, HRESP_OKAY);

      // Error stays two cycles regardless of wait states
      xfer(0, 32'h104, HSIZE_WORD, 4'hF, 32'h0, rd, rf, rl, waits);
      chk("ws_err_waits", 32'(waits), 1);
      chk("ws_err_resp1", rf, HRESP_ERROR);
      chk("ws_err_resp2", rl, HRESP_ERROR);

`ifdef AHB_SLAVE_DMA_REQ_EN
      xfer(1, 32'h100, HSIZE_WORD, 4'hF, 32'h1, rd, rf, rl, waits);
      @(negedge clk);
      chk("ws_dreq_set", dreq, 1);
`endif

      // Reset during a wait cycle drops the write and clears outputs at once
      @(negedge clk);
      hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h0C;
      hsize = HSIZE_WORD; wstrb = 4'hF;
      @(negedge clk);
      idle_bus();
      hwdata = 32'hFFFFFFFF;
      chk("rw_in_wait", ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_ready", ready, 1);
      chk("rw_resp", resp, HRESP_OKAY);
      chk("rw_dreq", dreq, 0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 32'h0C, HSIZE_WORD, 4'hF, 32'h0, rd, rf, rl, waits);
      chk("rw_mem_kept", rd, 32'h0F0E0D0C);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
